// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: extracts and extends the selected immediate
// and presents it one cycle later from a 2-entry skid buffer. in_ready is registered.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_main_imm;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_main_ill;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;

  logic [31:0]      w_raw;
  logic             w_sx;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_acc;
  logic             w_pop;
  logic             w_unused_opcode;

  assign w_unused_opcode = ^in_inst[6:0];

  // w_raw is already the 32-bit value; w_sx says whether to sign-fill beyond bit 31
  always_comb begin
    w_raw = '0;
    w_sx  = 1'b1;
    w_ill = 1'b0;
    case (in_sel)
      3'b000: w_raw = {{20{in_inst[31]}}, in_inst[31:20]};
      3'b001: w_raw = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      3'b010: w_raw = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                       in_inst[11:8], 1'b0};
      3'b011: w_raw = {in_inst[31:12], 12'b0};
      3'b100: w_raw = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                       in_inst[30:21], 1'b0};
      3'b101: begin
        w_sx  = 1'b0;
        w_raw = {27'b0, in_inst[19:15]};
      end
      3'b110: begin
        w_sx  = 1'b0;
        w_raw = (XLEN == 64) ? {26'b0, in_inst[25:20]} : {27'b0, in_inst[24:20]};
      end
      default: begin
        w_sx  = 1'b0;
        w_ill = 1'b1;
      end
    endcase
    w_imm = w_sx ? XLEN'($signed(w_raw)) : XLEN'(w_raw);
  end

  assign w_acc = in_valid && r_in_ready;
  assign w_pop = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_imm  <= '0;
      r_main_tag  <= '0;
      r_main_ill  <= 1'b0;
      r_skid_imm  <= '0;
      r_skid_tag  <= '0;
      r_skid_ill  <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_main_imm  <= w_imm;
            r_main_tag  <= in_tag;
            r_main_ill  <= w_ill;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_acc && w_pop) begin
            r_main_imm <= w_imm;
            r_main_tag <= in_tag;
            r_main_ill <= w_ill;
          end else if (w_acc) begin
            r_skid_imm <= w_imm;
            r_skid_tag <= in_tag;
            r_skid_ill <= w_ill;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_main_imm <= r_skid_imm;
            r_main_tag <= r_skid_tag;
            r_main_ill <= r_skid_ill;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_main_imm;
  assign out_tag     = r_main_tag;
  assign out_illegal = r_main_ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Drives an XLEN=32 and an XLEN=64 instance with identical traffic and checks both
// against an arithmetic immediate model and a queue-based FIFO occupancy model.
module tb_imm_gen_stage;

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_sel;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  ent_t q32[$];
  ent_t q64[$];

  logic        ov_en;
  logic [63:0] ov32, ov64;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
    .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32));

  imm_gen_stage #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
    .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic longint sext(input longint x, input int n);
    if (((x >> (n - 1)) & 1) != 0) return x - (longint'(1) << n);
    return x;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] sel,
                                          input int xlen);
    longint u, v;
    u = {32'b0, inst};
    case (sel)
      3'd0: v = sext(u >> 20, 12);
      3'd1: v = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      3'd2: v = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                     (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      3'd3: v = sext(u & 64'hFFFF_F000, 32);
      3'd4: v = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                     (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      3'd5: v = (u >> 15) & 31;
      3'd6: v = (u >> 20) & ((xlen == 64) ? 63 : 31);
      default: v = 0;
    endcase
    return (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  // One clock: check outputs against the model, advance the model across the edge.
  task automatic tick(output bit acc);
    ent_t e32, e64;
    bit   pop;
    chk("valid32", 64'(vld32), 64'(q32.size() != 0));
    chk("ready32", 64'(rdy32), 64'(q32.size() < 2));
    chk("valid64", 64'(vld64), 64'(q64.size() != 0));
    chk("ready64", 64'(rdy64), 64'(q64.size() < 2));
    if (q32.size() != 0) begin
      chk("imm32", 64'(imm32), q32[0].imm);
      chk("tag32", 64'(tag32), 64'(q32[0].tag));
      chk("ill32", 64'(ill32), 64'(q32[0].ill));
    end
    if (q64.size() != 0) begin
      chk("imm64", imm64, q64[0].imm);
      chk("tag64", 64'(tag64), 64'(q64[0].tag));
      chk("ill64", 64'(ill64), 64'(q64[0].ill));
    end
    acc = in_valid && (q32.size() < 2);
    pop = (q32.size() != 0) && out_ready;
    e32.imm = ov_en ? ov32 : ref_imm(in_inst, in_sel, 32);
    e64.imm = ov_en ? ov64 : ref_imm(in_inst, in_sel, 64);
    e32.tag = in_tag;
    e64.tag = in_tag;
    e32.ill = (in_sel == 3'b111);
    e64.ill = (in_sel == 3'b111);
    @(posedge clk);
    if (pop) begin
      void'(q32.pop_front());
      void'(q64.pop_front());
    end
    if (acc) begin
      q32.push_back(e32);
      q64.push_back(e64);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] inst, input logic [2:0] sel, input logic [4:0] tag,
                     input logic [63:0] e32, input logic [63:0] e64);
    bit a;
    in_valid = 1'b1;
    in_inst  = inst;
    in_sel   = sel;
    in_tag   = tag;
    ov_en    = 1'b1;
    ov32     = e32;
    ov64     = e64;
    tick(a);
    chk("accepted", 64'(a), 64'd1);
    ov_en    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_vld32"}, 64'(vld32), 64'd0);
    chk({name, "_rdy32"}, 64'(rdy32), 64'd1);
    chk({name, "_imm32"}, 64'(imm32), 64'd0);
    chk({name, "_tag32"}, 64'(tag32), 64'd0);
    chk({name, "_ill32"}, 64'(ill32), 64'd0);
    chk({name, "_vld64"}, 64'(vld64), 64'd0);
    chk({name, "_rdy64"}, 64'(rdy64), 64'd1);
    chk({name, "_imm64"}, imm64, 64'd0);
  endtask

  initial begin
    bit a;
    int nt;
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_sel    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    ov_en     = 1'b0;
    ov32      = '0;
    ov64      = '0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // back-to-back with out_ready high: no bubbles
    out_ready = 1'b1;
    put(32'hFFF00093, 3'd0, 5'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    put(32'hFE000EE3, 3'd2, 5'd2, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    put(32'h12345037, 3'd3, 5'd3, 64'h1234_5000, 64'h1234_5000);
    put(32'h0080006F, 3'd4, 5'd4, 64'h8, 64'h8);
    put(32'h800000B7, 3'd3, 5'd5, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    put(32'h03F01013, 3'd6, 5'd6, 64'h1F, 64'h3F);
    put(32'h340FD073, 3'd5, 5'd7, 64'h1F, 64'h1F);
    put(32'hDEADBEEF, 3'd7, 5'd8, 64'h0, 64'h0);
    put(32'h00100093, 3'd0, 5'd9, 64'h1, 64'h1);
    idle(2);

    // backpressure: two accepts fill the buffer, tag 1 held, then drain in order
    out_ready = 1'b0;
    nt = 1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_inst = $urandom;
      in_sel  = 3'($urandom_range(0, 6));
      in_tag  = 5'(nt);
      tick(a);
      if (a) nt++;
    end
    chk("bp_accepts", 64'(nt - 1), 64'd2);
    out_ready = 1'b1;
    cyc = 0;
    while (nt <= 4 && cyc < 20) begin
      in_inst = $urandom;
      in_sel  = 3'($urandom_range(0, 6));
      in_tag  = 5'(nt);
      tick(a);
      if (a) nt++;
      cyc++;
    end
    chk("bp_all_sent", 64'(nt), 64'd5);
    idle(3);

    // reset between edges while two entries are buffered
    out_ready = 1'b0;
    put(32'h00500113, 3'd0, 5'd10, 64'h5, 64'h5);
    put(32'h00600113, 3'd0, 5'd11, 64'h6, 64'h6);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    put(32'h7FF00093, 3'd0, 5'd12, 64'h7FF, 64'h7FF);
    idle(2);

    // random soak
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_inst   = $urandom;
      in_sel    = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick(a);
      cyc++;
    end
    chk("soak_budget", 64'(n_acc >= 10000), 64'd1);
    out_ready = 1'b1;
    idle(4);
    chk("drained", 64'(q32.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
